fwd_scoreboard_unit: RTL and testbench
======================================

Name: fwd_scoreboard_unit

Overview:
Parametrised operand-forwarding and hazard unit for the pipelined CPU. Generalises the two-operand MEM/WB forwarding select to NUM_SRC source operands and FWD_STAGES producer stages. Adds a per-register latency scoreboard that stalls issue for load-use, multi-cycle (mul/div) and WAW hazards. Sits between the ID stage (issue/stall) and the EX operand muxes (forward selects).

Parameters:
REG_AW, 5, register-address width; the table holds 2**REG_AW entries, and register 0 is hardwired zero.
NUM_SRC, 2, source operands per instruction.
FWD_STAGES, 2, producer stages after EX; stage 1 is nearest (MEM) and stage FWD_STAGES is oldest (WB).
MAX_LAT, 4, maximum result latency in cycles; counter width CW = clog2(MAX_LAT+1).
Derived: SELW = clog2(FWD_STAGES+1).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
st_rd_i  in  FWD_STAGES*REG_AW  destination register of each producer stage; stage k occupies slice k-1.
st_we_i  in  FWD_STAGES  register-write enable of each producer stage.
ex_rs_i  in  NUM_SRC*REG_AW  source registers of the instruction in EX.
fwd_sel_o  out  NUM_SRC*SELW  per-operand select: 0 = register file, k = stage k.
id_valid_i  in  1  valid instruction in ID.
id_rs_i  in  NUM_SRC*REG_AW  ID source registers.
id_rs_used_i  in  NUM_SRC  per-operand "source actually read" flag.
id_we_i  in  1  ID instruction writes a register.
id_rd_i  in  REG_AW  ID destination register.
id_lat_i  in  CW  ID result latency; 1 = ALU, 2 = load, and so on.
flush_i  in  1  kill the ID instruction this cycle.
stall_o  out  1  hold IF/ID and insert a bubble into EX.
issue_o  out  1  ID instruction issues this cycle.
busy_o  out  1  any scoreboard counter is nonzero.

Behaviour:
- Reset: asynchronous on rst_n low. All counters clear to 0. The outputs stall_o, issue_o and busy_o are 0, and fwd_sel_o is 0 whenever the inputs do not match any producer.
- Forward select (combinational, zero latency):
  - Operand j selects the lowest k with st_we_i[k], st_rd_i[k]==ex_rs_i[j] and st_rd_i[k]!=0.
  - The nearest stage always wins. If no stage matches, the select is 0.
- Scoreboard: cnt[r], CW bits per register.
  - Each rising edge, every nonzero cnt decrements by 1.
  - On issue, cnt[id_rd_i] <= lat_eff, where lat_eff = min(id_lat_i, MAX_LAT). Issue overrides the decrement for that entry in the same cycle.
  - cnt[0] stays 0. Issue with id_rd_i==0, with id_lat_i==0, or with id_we_i==0 leaves the table unchanged.
- Hazard terms, all computed from registered cnt and current ID inputs:
  - RAW: id_valid_i, id_rs_used_i[j], id_rs_i[j]!=0 and cnt[id_rs_i[j]] >= 2.
  - WAW: id_valid_i, id_we_i, id_rd_i!=0 and cnt[id_rd_i] > lat_eff.
- stall_o = (RAW for any j OR WAW) AND NOT flush_i.
- issue_o = id_valid_i AND NOT stall_o AND NOT flush_i.
- Resulting latencies: a load (lat 2) followed by a dependent instruction gives a 1-cycle stall. A lat-L producer gives L-1 stall cycles. ALU back-to-back gives no stall, with the operand supplied via fwd_sel = 1.
- Flush has priority: no issue and no stall. The table keeps decrementing, so older in-flight producers remain tracked.
- busy_o = OR of all nonzero cnt, registered-state based.
- Reset asserted mid-stall: the table clears immediately and stall_o drops asynchronously.

Decomposition:
- Shared package cpu_pkg holds REG_AW, the latency constants LAT_ALU=1, LAT_LOAD=2 and LAT_MUL=4, and the fwd_sel encoding constants FWD_RF=0 and FWD_STAGE1=1.
- One sub-module, fwd_select: the combinational priority forward select for a single operand, instantiated NUM_SRC times.
- The scoreboard and hazard logic stay in the top module.

Test Plan:
1. Reset, then release with all inputs 0 -> stall_o=0, issue_o=0, busy_o=0, fwd_sel_o=0.
2. st_we=2'b11, st_rd={5,5}, ex_rs0=5 -> sel0=1. Drop st_we[0], keep st_rd[1]=5, ex_rs1=5 -> sel1=2. With st_rd=0 and we=1 on any stage -> sel=0.
3. Load-use: issue rd=7, lat=2; next cycle ID rs0=7 used -> stall_o=1 for exactly 1 cycle, then issue_o=1. Repeat with id_rs_used_i[0]=0 -> no stall.
4. Mul: issue rd=9, lat=4; next cycle ALU rs1=9 -> stall_o high 3 cycles. Separately, ALU writing rd=9 lat=1 one cycle after the mul -> WAW stall until cnt[9]=1.
5. Simultaneous: flush_i=1 during a RAW hazard -> stall_o=0 and issue_o=0, while the counter still decrements. Issue rd=3, lat=4 while cnt[3]=1 -> WAW check 1>4 is false, so issue proceeds and cnt[3]=4 next cycle.
6. Pull rst_n low while stalled on mul -> stall_o=0 and busy_o=0 immediately. After release, a consumer of rd=9 issues with no stall.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants for the operand-forwarding and hazard logic.
//   REG_AW              : register-address width
//   LAT_ALU/LOAD/MUL    : result latencies in cycles, issue to value available for forwarding
//   FWD_RF / FWD_STAGE1 : forward-select encodings (register file, nearest producer stage)
package cpu_pkg;

  localparam int unsigned REG_AW = 5;

  localparam int unsigned LAT_ALU  = 1;
  localparam int unsigned LAT_LOAD = 2;
  localparam int unsigned LAT_MUL  = 4;

  localparam int unsigned FWD_RF     = 0;
  localparam int unsigned FWD_STAGE1 = 1;

endpackage

// File: rtl/fwd_select.sv
// Priority forward select for one source operand.
//   stRd_i : destination register of each producer stage; stage k occupies slice k-1
//   stWe_i : register-write enable of each producer stage
//   rs_i   : source register of the operand in EX
//   sel_o  : 0 = register file, k = forward from stage k (nearest matching stage wins)
module fwd_select import cpu_pkg::*; #(
  parameter int unsigned REG_AW     = cpu_pkg::REG_AW,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned SELW       = $clog2(FWD_STAGES + 1)
) (
  input  logic [FWD_STAGES*REG_AW-1:0] stRd_i,
  input  logic [FWD_STAGES-1:0]        stWe_i,
  input  logic [REG_AW-1:0]            rs_i,
  output logic [SELW-1:0]              sel_o
);

  // Walk from the oldest stage down so the nearest match is the last one written.
  always_comb begin
    sel_o = SELW'(FWD_RF);
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (stWe_i[k-1] && (stRd_i[(k-1)*REG_AW +: REG_AW] == rs_i) &&
          (stRd_i[(k-1)*REG_AW +: REG_AW] != '0)) begin
        sel_o = SELW'(k);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Operand-forwarding and issue-hazard unit.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   st_rd_i / st_we_i   : producer-stage destinations and write enables (stage 1 = MEM)
//   ex_rs_i / fwd_sel_o : EX source registers and per-operand forward selects
//   id_*                : instruction in ID (valid, sources, used flags, write, dest, latency)
//   flush_i             : kill the ID instruction this cycle
//   stall_o / issue_o   : hold ID and bubble EX / ID instruction issues
//   busy_o              : some register still has a result in flight
// Each register carries a down-counter of cycles until its pending result is written.
// A count of 1 means the value is one stage away and can be forwarded, so only
// counts of 2 or more block a reader.
module fwd_scoreboard_unit import cpu_pkg::*; #(
  parameter int unsigned REG_AW     = cpu_pkg::REG_AW,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned MAX_LAT    = 4,
  localparam int unsigned CW        = $clog2(MAX_LAT + 1),
  localparam int unsigned SELW      = $clog2(FWD_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [FWD_STAGES*REG_AW-1:0] st_rd_i,
  input  logic [FWD_STAGES-1:0]        st_we_i,
  input  logic [NUM_SRC*REG_AW-1:0]    ex_rs_i,
  output logic [NUM_SRC*SELW-1:0]      fwd_sel_o,
  input  logic                         id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0]    id_rs_i,
  input  logic [NUM_SRC-1:0]           id_rs_used_i,
  input  logic                         id_we_i,
  input  logic [REG_AW-1:0]            id_rd_i,
  input  logic [CW-1:0]                id_lat_i,
  input  logic                         flush_i,
  output logic                         stall_o,
  output logic                         issue_o,
  output logic                         busy_o
);

  localparam int unsigned NumRegs = 1 << REG_AW;

  logic [CW-1:0]     cntQ [NumRegs];
  logic [CW-1:0]     cntD [NumRegs];
  logic [CW-1:0]     latEff;
  logic [REG_AW-1:0] srcReg;
  logic              rawHit;
  logic              wawHit;

  // Forward selects, one per EX operand.
  for (genvar j = 0; j < NUM_SRC; j++) begin : gSrc
    fwd_select #(
      .REG_AW     (REG_AW),
      .FWD_STAGES (FWD_STAGES),
      .SELW       (SELW)
    ) uFwdSel (
      .stRd_i (st_rd_i),
      .stWe_i (st_we_i),
      .rs_i   (ex_rs_i[j*REG_AW +: REG_AW]),
      .sel_o  (fwd_sel_o[j*SELW +: SELW])
    );
  end

  // Hazard detection from the registered table and the current ID instruction.
  always_comb begin
    latEff = (id_lat_i > CW'(MAX_LAT)) ? CW'(MAX_LAT) : id_lat_i;
    rawHit = 1'b0;
    srcReg = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      srcReg = id_rs_i[j*REG_AW +: REG_AW];
      if (id_rs_used_i[j] && (srcReg != '0) && (cntQ[srcReg] > CW'(LAT_ALU))) begin
        rawHit = 1'b1;
      end
    end
    rawHit = rawHit & id_valid_i;
    // A younger write must not land before an older in-flight write to the same register.
    wawHit  = id_valid_i && id_we_i && (id_rd_i != '0) && (cntQ[id_rd_i] > latEff);
    stall_o = (rawHit || wawHit) && !flush_i;
    issue_o = id_valid_i && !stall_o && !flush_i;
  end

  // Next table state: age every entry, then overwrite the issuing destination.
  always_comb begin
    for (int r = 0; r < NumRegs; r++) begin
      cntD[r] = (cntQ[r] != '0) ? (cntQ[r] - CW'(1)) : '0;
    end
    if (issue_o && id_we_i && (id_rd_i != '0) && (id_lat_i != '0)) begin
      cntD[id_rd_i] = latEff;
    end
    cntD[0] = '0;
  end

  always_comb begin
    busy_o = 1'b0;
    for (int r = 0; r < NumRegs; r++) begin
      busy_o = busy_o | (cntQ[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NumRegs; r++) begin
        cntQ[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NumRegs; r++) begin
        cntQ[r] <= cntD[r];
      end
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Self-checking bench for fwd_scoreboard_unit: directed scenarios plus randomized traffic,
// compared against a model that tracks, per register, the absolute cycle its result is ready.
module tb_fwd_scoreboard_unit;

  localparam int RegAw  = 5;
  localparam int Stages = 2;
  localparam int MaxLat = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  st_rd_i;
  logic [1:0]  st_we_i;
  logic [9:0]  ex_rs_i;
  logic [3:0]  fwd_sel_o;
  logic        id_valid_i;
  logic [9:0]  id_rs_i;
  logic [1:0]  id_rs_used_i;
  logic        id_we_i;
  logic [4:0]  id_rd_i;
  logic [2:0]  id_lat_i;
  logic        flush_i;
  logic        stall_o;
  logic        issue_o;
  logic        busy_o;

  int availAt [32];
  int cyc;
  int nTests = 0;
  int nFail  = 0;
  int lastStall, lastIssue, lastBusy;
  int nStall, gotIssue;

  always #5 clk = ~clk;

  fwd_scoreboard_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_rd_i      (st_rd_i),
    .st_we_i      (st_we_i),
    .ex_rs_i      (ex_rs_i),
    .fwd_sel_o    (fwd_sel_o),
    .id_valid_i   (id_valid_i),
    .id_rs_i      (id_rs_i),
    .id_rs_used_i (id_rs_used_i),
    .id_we_i      (id_we_i),
    .id_rd_i      (id_rd_i),
    .id_lat_i     (id_lat_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .issue_o      (issue_o),
    .busy_o       (busy_o)
  );

  task automatic checkEq(input string tag, input int obs, input int exp);
    nTests++;
    if (obs != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles still pending on register r, as seen during the current cycle.
  function automatic int cntOf(input int r);
    if (r == 0) return 0;
    return (availAt[r] > cyc) ? availAt[r] - cyc : 0;
  endfunction

  function automatic int expSel(input int j);
    int rs;
    rs = int'(ex_rs_i[j*RegAw +: RegAw]);
    for (int k = 1; k <= Stages; k++) begin
      if (st_we_i[k-1] && int'(st_rd_i[(k-1)*RegAw +: RegAw]) == rs && rs != 0) return k;
    end
    return 0;
  endfunction

  function automatic void resetModel();
    cyc = 0;
    for (int r = 0; r < 32; r++) availAt[r] = 0;
  endfunction

  // Check all outputs mid-cycle against the model, then advance one clock.
  task automatic cycleCheck();
    int  latEff, expStall, expIssue, expBusy, rs;
    bit  raw, waw;
    @(negedge clk);
    latEff = (int'(id_lat_i) > MaxLat) ? MaxLat : int'(id_lat_i);
    raw = 1'b0;
    for (int j = 0; j < 2; j++) begin
      rs = int'(id_rs_i[j*RegAw +: RegAw]);
      if (id_valid_i && id_rs_used_i[j] && rs != 0 && cntOf(rs) >= 2) raw = 1'b1;
    end
    waw = id_valid_i && id_we_i && id_rd_i != 0 && cntOf(int'(id_rd_i)) > latEff;
    expStall = int'((raw || waw) && !flush_i);
    expIssue = int'(id_valid_i && expStall == 0 && !flush_i);
    expBusy = 0;
    for (int r = 1; r < 32; r++) if (cntOf(r) > 0) expBusy = 1;
    lastStall = int'(stall_o);
    lastIssue = int'(issue_o);
    lastBusy  = int'(busy_o);
    checkEq("stall", lastStall, expStall);
    checkEq("issue", lastIssue, expIssue);
    checkEq("busy", lastBusy, expBusy);
    checkEq("fwd_sel0", int'(fwd_sel_o[1:0]), expSel(0));
    checkEq("fwd_sel1", int'(fwd_sel_o[3:2]), expSel(1));
    @(posedge clk);
    if (expIssue != 0 && id_we_i && id_rd_i != 0 && id_lat_i != 0) begin
      availAt[id_rd_i] = cyc + 1 + latEff;
    end
    cyc++;
    #1;
  endtask

  task automatic setId(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                       input bit we, input int rd, input int lat, input bit fl);
    id_valid_i   = v;
    id_rs_i      = {5'(rs1), 5'(rs0)};
    id_rs_used_i = used;
    id_we_i      = we;
    id_rd_i      = 5'(rd);
    id_lat_i     = 3'(lat);
    flush_i      = fl;
  endtask

  task automatic drain();
    setId(0, 0, 0, 2'b00, 0, 0, 0, 0);
    repeat (5) cycleCheck();
  endtask

  // Hold the current ID inputs until they issue (bounded), counting stall cycles.
  task automatic countStalls(output int n, output int iss);
    n = 0;
    iss = 0;
    for (int i = 0; i < 8; i++) begin
      cycleCheck();
      if (lastIssue != 0) begin
        iss = 1;
        break;
      end
      n += lastStall;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    st_rd_i = '0;
    st_we_i = '0;
    ex_rs_i = '0;
    setId(0, 0, 0, 2'b00, 0, 0, 0, 0);
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkEq("rst_stall", int'(stall_o), 0);
    checkEq("rst_busy", int'(busy_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    resetModel();

    // Idle after reset.
    cycleCheck();
    checkEq("idle_issue", lastIssue, 0);

    // Forward priority.
    st_we_i = 2'b11; st_rd_i = {5'd5, 5'd5}; ex_rs_i = {5'd0, 5'd5};
    cycleCheck();
    checkEq("fwd_near", int'(fwd_sel_o[1:0]), 1);
    st_we_i = 2'b10; ex_rs_i = {5'd5, 5'd5};
    cycleCheck();
    checkEq("fwd_old", int'(fwd_sel_o[3:2]), 2);
    st_we_i = 2'b11; st_rd_i = '0; ex_rs_i = '0;
    cycleCheck();
    checkEq("fwd_r0", int'(fwd_sel_o), 0);

    // Load-use: one stall.
    setId(1, 0, 0, 2'b00, 1, 7, 2, 0);
    cycleCheck();
    setId(1, 7, 0, 2'b01, 0, 0, 1, 0);
    countStalls(nStall, gotIssue);
    checkEq("lu_stalls", nStall, 1);
    checkEq("lu_issue", gotIssue, 1);
    drain();
    setId(1, 0, 0, 2'b00, 1, 7, 2, 0);
    cycleCheck();
    setId(1, 7, 0, 2'b00, 0, 0, 1, 0);
    cycleCheck();
    checkEq("lu_unused", lastStall, 0);
    drain();

    // Mul RAW: three stalls.
    setId(1, 0, 0, 2'b00, 1, 9, 4, 0);
    cycleCheck();
    setId(1, 0, 9, 2'b10, 1, 10, 1, 0);
    countStalls(nStall, gotIssue);
    checkEq("mul_stalls", nStall, 3);
    drain();

    // Mul WAW: ALU writing the same register waits until cnt reaches 1.
    setId(1, 0, 0, 2'b00, 1, 9, 4, 0);
    cycleCheck();
    setId(1, 0, 0, 2'b00, 1, 9, 1, 0);
    countStalls(nStall, gotIssue);
    checkEq("waw_stalls", nStall, 3);
    drain();

    // Flush during RAW: no stall, no issue, table still ages.
    setId(1, 0, 0, 2'b00, 1, 9, 4, 0);
    cycleCheck();
    setId(1, 9, 0, 2'b01, 0, 0, 1, 1);
    cycleCheck();
    checkEq("fl_stall", lastStall, 0);
    checkEq("fl_issue", lastIssue, 0);
    checkEq("fl_busy", lastBusy, 1);
    setId(1, 9, 0, 2'b01, 0, 0, 1, 0);
    countStalls(nStall, gotIssue);
    checkEq("fl_stalls_after", nStall, 2);
    drain();

    // Reissue over cnt=1 with a longer latency: no WAW, new count takes effect.
    setId(1, 0, 0, 2'b00, 1, 3, 2, 0);
    cycleCheck();
    setId(0, 0, 0, 2'b00, 0, 0, 0, 0);
    cycleCheck();
    setId(1, 0, 0, 2'b00, 1, 3, 4, 0);
    cycleCheck();
    checkEq("reissue", lastIssue, 1);
    setId(1, 3, 0, 2'b01, 0, 0, 1, 0);
    countStalls(nStall, gotIssue);
    checkEq("reissue_stalls", nStall, 3);
    drain();

    // Reset while stalled on a mul.
    setId(1, 0, 0, 2'b00, 1, 9, 4, 0);
    cycleCheck();
    setId(1, 0, 9, 2'b10, 0, 0, 1, 0);
    cycleCheck();
    #2;
    checkEq("pre_rst_stall", int'(stall_o), 1);
    rst_n = 1'b0;
    #1;
    checkEq("mid_rst_stall", int'(stall_o), 0);
    checkEq("mid_rst_busy", int'(busy_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    resetModel();
    cycleCheck();
    checkEq("post_rst_issue", lastIssue, 1);
    drain();

    // Randomized traffic on a small register window to provoke hits.
    for (int i = 0; i < 400; i++) begin
      st_rd_i = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      st_we_i = 2'($urandom);
      ex_rs_i = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      setId(1'($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
            2'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 7) == 0));
      cycleCheck();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
